// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter sharing one memory_controller command
// port between NUM_REQ requesters. One transaction is outstanding at a time;
// the winner's cmd/addr/wdata are latched in IDLE, issued with a one-cycle
// mem_ready strobe, and the completion is routed back to the owning port.
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound the WAIT state with a
// TIMEOUT_CYC-cycle watchdog that completes the transaction with rsp_err=1.
module mem_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                mem_cmd,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_ready,
  input  logic                      mem_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b01;

  logic [2:0]        state;
  logic [OW-1:0]     last_grant;
  logic [OW-1:0]     owner;

  // Arbitration-stage (combinational) view of the requesters.
  logic [1:0]        cmd_arr   [NUM_REQ];
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic              win_found_p0;
  logic [OW-1:0]     win_idx_p0;
  logic [OW-1:0]     scan_idx;
  logic              win_legal_p0;

  // Latched request, held for the whole transaction.
  logic [1:0]        cmd_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]     wait_cnt;
  logic              tout_p1;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cmd_arr[g]   = req_cmd[2*g +: 2];
    assign addr_arr[g]  = req_addr[ADDR_W*g +: ADDR_W];
    assign wdata_arr[g] = req_wdata[DATA_W*g +: DATA_W];
  end

  // Round-robin pick: first pending port scanning upward from last_grant+1.
  always_comb begin
    win_found_p0 = 1'b0;
    win_idx_p0   = '0;
    scan_idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = OW'((int'(last_grant) + i) % NUM_REQ);
      if (!win_found_p0 && req_valid[scan_idx]) begin
        win_found_p0 = 1'b1;
        win_idx_p0   = scan_idx;
      end
    end
    win_legal_p0 = (cmd_arr[win_idx_p0] == CMD_WRITE) ||
                   (cmd_arr[win_idx_p0] == CMD_READ);
  end

  // Transaction FSM plus the request latch and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= OW'(NUM_REQ - 1);
      owner      <= '0;
      cmd_p1     <= CMD_NONE;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      rsp_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      tout_p1    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found_p0) begin
            owner      <= win_idx_p0;
            last_grant <= win_idx_p0;
            cmd_p1     <= cmd_arr[win_idx_p0];
            addr_p1    <= addr_arr[win_idx_p0];
            wdata_p1   <= wdata_arr[win_idx_p0];
            state      <= win_legal_p0 ? S_ISSUE : S_ERR;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt <= '0;
          tout_p1  <= 1'b0;
`endif
        end
        S_WAIT: begin
          if (mem_valid) begin
            // Write completions capture too, so rsp_rdata always reflects the last completion.
            rsp_rdata <= mem_rdata;
            state     <= S_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            rsp_rdata <= '0;
            tout_p1   <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        S_RESP:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode: strobes come from the state, payload from the latch.
  always_comb begin
    req_grant = '0;
    rsp_valid = '0;
    if (state == S_ISSUE || state == S_ERR) req_grant[owner] = 1'b1;
    if (state == S_RESP || state == S_ERR)  rsp_valid[owner] = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    rsp_err = (state == S_ERR) || ((state == S_RESP) && tout_p1);
`else
    rsp_err = (state == S_ERR);
`endif
    mem_ready = (state == S_ISSUE);
    mem_cmd   = (state == S_ISSUE || state == S_WAIT) ? cmd_p1 : CMD_NONE;
    mem_addr  = addr_p1;
    mem_wdata = wdata_p1;
    busy      = (state != S_IDLE);
  end

endmodule
